// File: rtl/oai33_bist_pkg.sv
// -----------------------------------------------------------------------------
// oai33_bist_pkg
// Shared definitions for the OAI33 built-in self-test sequencer:
//   - state_t     : sequencer states (IDLE, SETTLE, SAMPLE, DONE)
//   - NVEC        : number of exhaustive input vectors for a 6-input cell
//   - *_POS       : bit position of each cell pin inside the vector index
// -----------------------------------------------------------------------------
package oai33_bist_pkg;

  // State names carry an ST_ prefix so they cannot collide with the
  // SETTLE parameter or the DONE port of the sequencer.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int NVEC  = 64;
  localparam int VEC_W = 6;

  // Vector index -> cell pin mapping.
  localparam int A1_POS = 0;
  localparam int A2_POS = 1;
  localparam int A3_POS = 2;
  localparam int B1_POS = 3;
  localparam int B2_POS = 4;
  localparam int B3_POS = 5;

endpackage

// File: rtl/oai33_golden.sv
// -----------------------------------------------------------------------------
// oai33_golden
// Combinational reference model of one OAI33 cell, indexed by vector number.
// Ports:
//   v        [5:0] in  : vector index (A1=v0 .. B3=v5)
//   expected       out : !((A1|A2|A3) & (B1|B2|B3)) for that vector
// -----------------------------------------------------------------------------
module oai33_golden
  import oai33_bist_pkg::*;
(
  input  logic [VEC_W-1:0] v,
  output logic             expected
);

  // Golden OAI33 function evaluated on the vector bits.
  always_comb begin
    expected = ~((v[A1_POS] | v[A2_POS] | v[A3_POS]) &
                 (v[B1_POS] | v[B2_POS] | v[B3_POS]));
  end

endmodule

// File: rtl/oai33_bist_ctrl.sv
// -----------------------------------------------------------------------------
// oai33_bist_ctrl
// Exhaustive BIST sequencer for one OAI33 cell. Applies all 64 vectors,
// waits SETTLE cycles per vector, samples ZN and compares with the golden
// model, accumulating a saturating mismatch count and the first failing index.
// Ports:
//   CLK, RN (sync active-low reset), START (run request, IDLE only)
//   BUSY, DONE (1-cycle pulse), PASS, ERR_CNT[ERR_W], FAIL_VALID, FIRST_FAIL[6]
//   A1..B3 : registered stimulus to the cell, ZN : cell response
// -----------------------------------------------------------------------------
module oai33_bist_ctrl
  import oai33_bist_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int ERR_W  = 7
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             FAIL_VALID,
  output logic [5:0]       FIRST_FAIL,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             B1,
  output logic             B2,
  output logic             B3,
  input  logic             ZN
);

  localparam int               CNT_W     = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] VEC_LAST  = VEC_W'(NVEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ZERO  = {ERR_W{1'b0}};

  state_t             state_r;
  logic [VEC_W-1:0]   v_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [VEC_W-1:0]   stim_r;
  logic               exp_s;
  logic               mismatch_s;
  logic [ERR_W-1:0]   err_next_s;

  oai33_golden u_golden (
    .v        (v_r),
    .expected (exp_s)
  );

  // Case inequality makes an X/Z response from the cell count as a mismatch.
  always_comb begin
    mismatch_s = (ZN !== exp_s);
  end

  // Saturating increment of the mismatch counter for the vector being sampled.
  always_comb begin
    err_next_s = ERR_CNT;
    if (mismatch_s && (ERR_CNT != ERR_MAX)) begin
      err_next_s = ERR_CNT + ERR_W'(1);
    end else begin
      err_next_s = ERR_CNT;
    end
  end

  // Stimulus pins come straight from the stimulus register.
  assign A1 = stim_r[A1_POS];
  assign A2 = stim_r[A2_POS];
  assign A3 = stim_r[A3_POS];
  assign B1 = stim_r[B1_POS];
  assign B2 = stim_r[B2_POS];
  assign B3 = stim_r[B3_POS];

  // Sequencer FSM with vector/settle counters and result registers.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_r    <= ST_IDLE;
      v_r        <= 6'd0;
      cnt_r      <= {CNT_W{1'b0}};
      stim_r     <= 6'd0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      ERR_CNT    <= ERR_ZERO;
      FAIL_VALID <= 1'b0;
      FIRST_FAIL <= 6'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            state_r    <= ST_SETTLE;
            v_r        <= 6'd0;
            cnt_r      <= {CNT_W{1'b0}};
            stim_r     <= 6'd0;
            BUSY       <= 1'b1;
            PASS       <= 1'b0;
            ERR_CNT    <= ERR_ZERO;
            FAIL_VALID <= 1'b0;
            FIRST_FAIL <= 6'd0;
          end else begin
            stim_r <= 6'd0;
            BUSY   <= 1'b0;
          end
        end
        ST_SETTLE: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_SAMPLE;
          end else begin
            state_r <= ST_SETTLE;
          end
        end
        ST_SAMPLE: begin
          ERR_CNT <= err_next_s;
          if (mismatch_s && !FAIL_VALID) begin
            FIRST_FAIL <= v_r;
            FAIL_VALID <= 1'b1;
          end else begin
            FAIL_VALID <= FAIL_VALID;
          end
          // Terminal vector is detected before increment so v never wraps.
          if (v_r == VEC_LAST) begin
            state_r <= ST_DONE;
            DONE    <= 1'b1;
            PASS    <= (err_next_s == ERR_ZERO);
            stim_r  <= 6'd0;
          end else begin
            state_r <= ST_SETTLE;
            v_r     <= v_r + 6'd1;
            stim_r  <= v_r + 6'd1;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          DONE    <= 1'b0;
          BUSY    <= 1'b0;
          stim_r  <= 6'd0;
        end
        default: begin
          state_r <= ST_IDLE;
          DONE    <= 1'b0;
          BUSY    <= 1'b0;
          stim_r  <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oai33_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_oai33_bist_ctrl
// Two sequencers (ERR_W=7 and ERR_W=5) share START/RN and each drive their
// own modelled cell (good, stuck-0, stuck-1 or inverted). A behavioural model
// derives every output from the elapsed cycles since START acceptance and
// is compared on every falling edge; directed runs add literal expectations.
// -----------------------------------------------------------------------------
module tb_oai33_bist_ctrl;

  localparam int S      = 2;
  localparam int RUNLEN = 64 * (S + 1);

  logic       clk;
  logic       rn;
  logic       start;
  logic       busy_a, done_a, pass_a, fv_a, zn_a;
  logic [6:0] err_a;
  logic [5:0] ff_a;
  logic       a1_a, a2_a, a3_a, b1_a, b2_a, b3_a;
  logic       busy_b, done_b, pass_b, fv_b, zn_b;
  logic [4:0] err_b;
  logic [5:0] ff_b;
  logic       a1_b, a2_b, a3_b, b1_b, b2_b, b3_b;
  logic [5:0] stim_a, stim_b;
  logic [5:0] g_v;
  logic       g_exp;

  int mode_a, mode_b;      // 0 good, 1 stuck0, 2 stuck1, 3 inverted
  int rmode_a, rmode_b;    // mode latched at START acceptance
  int cyc;
  int k;
  bit active;
  int errors;
  int checks;

  oai33_bist_ctrl #(.SETTLE(S), .ERR_W(7)) dut (
    .CLK(clk), .RN(rn), .START(start), .BUSY(busy_a), .DONE(done_a),
    .PASS(pass_a), .ERR_CNT(err_a), .FAIL_VALID(fv_a), .FIRST_FAIL(ff_a),
    .A1(a1_a), .A2(a2_a), .A3(a3_a), .B1(b1_a), .B2(b2_a), .B3(b3_a),
    .ZN(zn_a)
  );

  oai33_bist_ctrl #(.SETTLE(S), .ERR_W(5)) dut5 (
    .CLK(clk), .RN(rn), .START(start), .BUSY(busy_b), .DONE(done_b),
    .PASS(pass_b), .ERR_CNT(err_b), .FAIL_VALID(fv_b), .FIRST_FAIL(ff_b),
    .A1(a1_b), .A2(a2_b), .A3(a3_b), .B1(b1_b), .B2(b2_b), .B3(b3_b),
    .ZN(zn_b)
  );

  oai33_golden u_gold (.v(g_v), .expected(g_exp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit gold(int v);
    return !(((v % 8) != 0) && ((v / 8) != 0));
  endfunction

  function automatic bit resp(int mode, int v);
    case (mode)
      0:       return gold(v);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return !gold(v);
    endcase
  endfunction

  assign stim_a = {b3_a, b2_a, b1_a, a3_a, a2_a, a1_a};
  assign stim_b = {b3_b, b2_b, b1_b, a3_b, a2_b, a1_b};

  always_comb begin
    zn_a = resp(mode_a, int'(stim_a));
    zn_b = resp(mode_b, int'(stim_b));
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Model bookkeeping: edge counter, reset and START acceptance.
  always @(posedge clk) begin
    bit idle_before;
    cyc = cyc + 1;
    idle_before = !active || ((cyc - 1 - k) > RUNLEN);
    if (!rn) begin
      active = 1'b0;
    end else if (start && idle_before) begin
      active  = 1'b1;
      k       = cyc;
      rmode_a = mode_a;
      rmode_b = mode_b;
    end
  end

  task automatic check_side(input string tag, input int rmode, input int maxerr,
                            input int busy, input int done, input int pass,
                            input int err, input int fv, input int ff, input int stim);
    int t, nv, raw, total, first;
    int e_busy, e_done, e_pass, e_err, e_fv, e_ff, e_stim;
    e_busy = 0; e_done = 0; e_pass = 0; e_err = 0; e_fv = 0; e_ff = 0; e_stim = 0;
    if (active) begin
      t  = cyc - k;
      nv = t / (S + 1);
      if (nv > 64) nv = 64;
      raw = 0; total = 0; first = -1;
      for (int i = 0; i < 64; i++) begin
        if (resp(rmode, i) != gold(i)) begin
          total++;
          if (i < nv) begin
            raw++;
            if (first < 0) first = i;
          end
        end
      end
      e_busy = (t <= RUNLEN) ? 1 : 0;
      e_done = (t == RUNLEN) ? 1 : 0;
      e_pass = (t >= RUNLEN && total == 0) ? 1 : 0;
      e_err  = (raw > maxerr) ? maxerr : raw;
      e_fv   = (raw > 0) ? 1 : 0;
      e_ff   = (first < 0) ? 0 : first;
      e_stim = (t < RUNLEN) ? t / (S + 1) : 0;
    end
    chk({tag, ".busy"}, busy, e_busy);
    chk({tag, ".done"}, done, e_done);
    chk({tag, ".pass"}, pass, e_pass);
    chk({tag, ".err_cnt"}, err, e_err);
    chk({tag, ".fail_valid"}, fv, e_fv);
    chk({tag, ".first_fail"}, ff, e_ff);
    chk({tag, ".stim"}, stim, e_stim);
  endtask

  // Per-cycle scoreboard compare on the falling edge.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      check_side("m7", rmode_a, 127, busy_a, done_a, pass_a, int'(err_a),
                 fv_a, int'(ff_a), int'(stim_a));
      check_side("m5", rmode_b, 31, busy_b, done_b, pass_b, int'(err_b),
                 fv_b, int'(ff_b), int'(stim_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int edge_k);
    start = 1'b1;
    tick();
    edge_k = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output int edge_d);
    bit found;
    found  = 1'b0;
    edge_d = -1;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if (done_a) begin
        found  = 1'b1;
        edge_d = cyc;
      end
    end
    if (!found) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int ka, da, d2, ones_m, ones_g;
    bit seen;
    errors = 0; checks = 0; cyc = 0; k = 0; active = 1'b0;
    rn = 1'b0; start = 1'b0; mode_a = 0; mode_b = 0; rmode_a = 0; rmode_b = 0;
    g_v = 6'd0;
    tick(); tick();
    chk("reset.busy", busy_a, 0);
    chk("reset.stim", int'(stim_a), 0);
    rn = 1'b1;

    // Golden sub-module against the bench function; pin the 15/49 split.
    ones_m = 0; ones_g = 0;
    for (int i = 0; i < 64; i++) begin
      g_v = 6'(i);
      #1;
      chk("golden", g_exp, gold(i));
      ones_m += int'(gold(i));
      ones_g += int'(g_exp);
    end
    chk("gold_ones_model", ones_m, 15);
    chk("gold_ones_rtl", ones_g, 15);

    // Run 1: good cell / inverted cell on ERR_W=5.
    mode_a = 0; mode_b = 3;
    tick();
    pulse_start(ka);
    wait_done(da);
    chk("r1.done_edge", da - ka, 192);
    chk("r1.pass", pass_a, 1);
    chk("r1.err", int'(err_a), 0);
    chk("r1.fv", fv_a, 0);
    chk("r1.sat_err", int'(err_b), 31);
    chk("r1.sat_ff", int'(ff_b), 0);
    tick();
    chk("r1.busy_low", busy_a, 0);

    // Run 2: stuck-0 / stuck-1.
    tick();
    mode_a = 1; mode_b = 2;
    pulse_start(ka);
    wait_done(da);
    chk("r2.err", int'(err_a), 15);
    chk("r2.ff", int'(ff_a), 0);
    chk("r2.pass", pass_a, 0);
    chk("r2.ff_b", int'(ff_b), 9);
    tick(); tick();
    chk("r2.hold_err", int'(err_a), 15);

    // Run 3: stuck-1, START re-asserted while busy.
    mode_a = 2; mode_b = 0;
    pulse_start(ka);
    for (int i = 0; i < 50; i++) tick();
    start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    wait_done(da);
    chk("r3.done_edge", da - ka, 192);
    chk("r3.err", int'(err_a), 49);
    chk("r3.ff", int'(ff_a), 9);
    chk("r3.pass_b", pass_b, 1);
    tick(); tick();

    // Run 4: START held through DONE -> restart after one idle cycle.
    mode_a = 0; mode_b = 0;
    start = 1'b1;
    tick();
    ka = cyc;
    wait_done(da);
    chk("r4.done_edge", da - ka, 192);
    tick();
    chk("r4.idle_busy", busy_a, 0);
    tick();
    chk("r4.restart_busy", busy_a, 1);
    start = 1'b0;
    wait_done(d2);
    chk("r4.second_done", d2 - da, 194);
    tick(); tick();

    // Run 5: reset for one edge while v=20, then a fresh full run.
    mode_a = 3; mode_b = 1;
    pulse_start(ka);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (stim_a == 6'd20) seen = 1'b1;
    end
    chk("r5.reached_v20", int'(seen), 1);
    rn = 1'b0;
    tick();
    rn = 1'b1;
    chk("r5.rst_busy", busy_a, 0);
    chk("r5.rst_err", int'(err_a), 0);
    chk("r5.rst_fv", fv_a, 0);
    chk("r5.rst_stim", int'(stim_a), 0);
    chk("r5.rst_err_b", int'(err_b), 0);
    tick();
    mode_a = 0; mode_b = 0;
    pulse_start(ka);
    wait_done(da);
    chk("r5.done_edge", da - ka, 192);
    chk("r5.pass", pass_a, 1);
    chk("r5.pass_b", pass_b, 1);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
